piezo_sound_arbiter: RTL and testbench

//  Shares the single PIEZO output among five sound requesters: horn, ESS, reverse, turn click and engine hum.

---
 rtl/piezo_arb_pkg.sv | 49 ++++
 rtl/piezo_nco.sv | 36 +++
 rtl/piezo_sound_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_piezo_sound_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_arb_pkg.sv
// Shared constants for the piezo sound arbiter: grant codes, FSM states,
// NCO step values and cadence timing.
package piezo_arb_pkg;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_ENG  = 3'd1;
  localparam logic [2:0] SRC_TURN = 3'd2;
  localparam logic [2:0] SRC_REV  = 3'd3;
  localparam logic [2:0] SRC_ESS  = 3'd4;
  localparam logic [2:0] SRC_HORN = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TONE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_OFF  = 2'd3;

  // f_out = step * 1e6 / 2^22
  localparam int unsigned STEP_HORN = 1845;
  localparam int unsigned STEP_ESS  = 4194;
  localparam int unsigned STEP_REV  = 3355;
  localparam int unsigned STEP_TURN = 6291;

  localparam int unsigned ESS_ON_MS  = 100;
  localparam int unsigned ESS_OFF_MS = 100;
  localparam int unsigned REV_ON_MS  = 300;
  localparam int unsigned REV_OFF_MS = 300;

  function automatic logic [2:0] arb_pick(input logic horn, input logic ess, input logic rev,
                                          input logic turn, input logic eng);
    logic [2:0] src;
    if (horn)      src = SRC_HORN;
    else if (ess)  src = SRC_ESS;
    else if (rev)  src = SRC_REV;
    else if (turn) src = SRC_TURN;
    else if (eng)  src = SRC_ENG;
    else           src = SRC_NONE;
    return src;
  endfunction

  // Horn and engine hum sound continuously; the rest follow an on/off cadence.
  function automatic logic [1:0] entry_state(input logic [2:0] src);
    logic [1:0] st;
    if (src == SRC_NONE)                         st = ST_IDLE;
    else if (src == SRC_HORN || src == SRC_ENG)  st = ST_TONE;
    else                                         st = ST_ON;
    return st;
  endfunction

endpackage

// File: rtl/piezo_nco.sv
// Phase-accumulator NCO; the accumulator MSB is the square-wave output.
module piezo_nco #(
  parameter int unsigned ACC_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] step,
  output logic             msb
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Clear wins over enable so a new grant always starts from phase 0.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign msb = acc_q[ACC_W-1];

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Fixed-priority arbiter sharing one PIEZO among horn, ESS, reverse, turn click and engine hum.
// Optional engine hum source is built only when PIEZO_ENGINE_TONE_EN is defined.
module piezo_sound_arbiter
  import piezo_arb_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ACC_W     = 22,
  parameter int unsigned CLICK_MS  = 20,
  parameter int unsigned US_PER_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        engine_on,
  input  logic        is_horn,
  input  logic        ess_active,
  input  logic        is_reverse,
  input  logic        turn_signal_on,
  input  logic [13:0] rpm,
  output logic        piezo_out,
  output logic [2:0]  grant
);

  localparam int unsigned US_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_W   = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;

  logic [US_W-1:0] us_cnt;
  logic [MS_W-1:0] ms_cnt;
  logic            us_tick;
  logic            ms_tick;

  logic [2:0]  grant_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] cad_q, cad_d;
  logic        click_pend, click_pend_d;
  logic        turn_prev;
  logic        piezo_q, piezo_d;

  logic        rev_req;
  logic        eng_req;
  logic        turn_edge;
  logic [2:0]  winner;
  logic        grant_chg;
  logic        turn_done;
  logic        sounding;
  logic [15:0] on_lim;
  logic [15:0] off_lim;
  logic [ACC_W-1:0] step;
  logic [ACC_W-1:0] eng_step;
  logic        nco_msb;

  // Prescalers free-run; only the cadence counter restarts on a grant change.
  assign us_tick = (us_cnt == US_W'(US_DIV - 1));
  assign ms_tick = us_tick && (ms_cnt == MS_W'(US_PER_MS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else begin
      us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
      if (ms_tick) begin
        ms_cnt <= '0;
      end else if (us_tick) begin
        ms_cnt <= ms_cnt + 1'b1;
      end
    end
  end

  assign rev_req   = is_reverse & engine_on;
  assign turn_edge = turn_signal_on & ~turn_prev;

`ifdef PIEZO_ENGINE_TONE_EN
  assign eng_req  = engine_on & (rpm != 14'd0);
  assign eng_step = ACC_W'(rpm);
`else
  logic unused_rpm;
  assign unused_rpm = ^rpm;
  assign eng_req    = 1'b0;
  assign eng_step   = '0;
`endif

  assign winner    = arb_pick(is_horn, ess_active, rev_req, click_pend, eng_req);
  assign grant_chg = (winner != grant_q);
  assign sounding  = (state_q == ST_TONE) || (state_q == ST_ON);

  always_comb begin
    step    = '0;
    on_lim  = 16'd1;
    off_lim = 16'd1;
    case (grant_q)
      SRC_HORN: step = ACC_W'(STEP_HORN);
      SRC_ESS: begin
        step    = ACC_W'(STEP_ESS);
        on_lim  = 16'(ESS_ON_MS);
        off_lim = 16'(ESS_OFF_MS);
      end
      SRC_REV: begin
        step    = ACC_W'(STEP_REV);
        on_lim  = 16'(REV_ON_MS);
        off_lim = 16'(REV_OFF_MS);
      end
      SRC_TURN: begin
        step   = ACC_W'(STEP_TURN);
        on_lim = 16'(CLICK_MS);
      end
      SRC_ENG:  step = eng_step;
      default:  step = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cad_d     = cad_q;
    turn_done = 1'b0;
    if (grant_chg) begin
      state_d = entry_state(winner);
      cad_d   = '0;
    end else if (ms_tick) begin
      case (state_q)
        ST_ON: begin
          if (cad_q == on_lim - 16'd1) begin
            cad_d = '0;
            // A click is a single ON phase; releasing click_pend hands grant on.
            if (grant_q == SRC_TURN) begin
              state_d   = ST_IDLE;
              turn_done = 1'b1;
            end else begin
              state_d = ST_OFF;
            end
          end else begin
            cad_d = cad_q + 16'd1;
          end
        end
        ST_OFF: begin
          if (cad_q == off_lim - 16'd1) begin
            cad_d   = '0;
            state_d = ST_ON;
          end else begin
            cad_d = cad_q + 16'd1;
          end
        end
        default: cad_d = cad_q;
      endcase
    end
  end

  // A click that cannot sound now is discarded rather than played late.
  always_comb begin
    click_pend_d = click_pend;
    if (grant_q > SRC_TURN) begin
      click_pend_d = 1'b0;
    end else if (turn_done) begin
      click_pend_d = 1'b0;
    end else if (turn_edge) begin
      click_pend_d = 1'b1;
    end
  end

  assign piezo_d = (grant_chg || !sounding) ? 1'b0 : nco_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= SRC_NONE;
      state_q    <= ST_IDLE;
      cad_q      <= '0;
      click_pend <= 1'b0;
      turn_prev  <= 1'b0;
      piezo_q    <= 1'b0;
    end else begin
      grant_q    <= winner;
      state_q    <= state_d;
      cad_q      <= cad_d;
      click_pend <= click_pend_d;
      turn_prev  <= turn_signal_on;
      piezo_q    <= piezo_d;
    end
  end

  piezo_nco #(
    .ACC_W (ACC_W)
  ) u_nco (
    .clk  (clk),
    .rst  (rst),
    .clr  (grant_chg | ~sounding),
    .en   (us_tick & sounding),
    .step (step),
    .msb  (nco_msb)
  );

  assign piezo_out = piezo_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Directed bench for piezo_sound_arbiter, scaled to 1 us per clock and 20 us per "ms".
module tb_piezo_sound_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        engine_on = 1'b0;
  logic        is_horn = 1'b0;
  logic        ess_active = 1'b0;
  logic        is_reverse = 1'b0;
  logic        turn_signal_on = 1'b0;
  logic [13:0] rpm = 14'd0;
  logic        piezo_out;
  logic [2:0]  grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piezo_sound_arbiter #(
    .CLK_HZ    (1_000_000),
    .ACC_W     (22),
    .CLICK_MS  (20),
    .US_PER_MS (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .engine_on      (engine_on),
    .is_horn        (is_horn),
    .ess_active     (ess_active),
    .is_reverse     (is_reverse),
    .turn_signal_on (turn_signal_on),
    .rpm            (rpm),
    .piezo_out      (piezo_out),
    .grant          (grant)
  );

  task automatic wait_grant(input logic [2:0] g, input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (grant == g) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic first_rise(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (piezo_out) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (piezo_out) highs++;
    end
  endtask

  task automatic skip(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  task automatic go_idle();
    engine_on = 1'b0; is_horn = 1'b0; ess_active = 1'b0;
    is_reverse = 1'b0; turn_signal_on = 1'b0; rpm = 14'd0;
    skip(50);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (grant !== 3'd0) begin
      errors++; $display("FAIL reset_grant: got %0d expected 0", grant);
    end
    checks++;
    if (piezo_out !== 1'b0) begin
      errors++; $display("FAIL reset_piezo: got %0b expected 0", piezo_out);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (grant !== 3'd0 || piezo_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_5ms: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_reverse();
    int c, h;
    engine_on = 1'b1; is_reverse = 1'b1;
    wait_grant(3'd3, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL rev_grant_latency: got %0d expected 1", c);
    end
    first_rise(700, c);
    checks++;
    if (c != 627) begin
      errors++; $display("FAIL rev_first_rise: got %0d expected 627", c);
    end
    count_high(5353, h);
    checks++;
    if (h == 0) begin
      errors++; $display("FAIL rev_on_window: got %0d highs expected >0", h);
    end
    skip(24);
    count_high(5966, h);
    checks++;
    if (h != 0) begin
      errors++; $display("FAIL rev_off_window: got %0d highs expected 0", h);
    end
    first_rise(700, c);
    checks++;
    if (c < 638 || c > 657) begin
      errors++; $display("FAIL rev_restart_rise: got %0d expected 638..657", c);
    end
    engine_on = 1'b0;
    wait_grant(3'd0, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL rev_engine_off: got %0d expected 1", c);
    end
    go_idle();
  endtask

  task automatic test_horn_preempt();
    int c, h;
    engine_on = 1'b1; is_reverse = 1'b1;
    wait_grant(3'd3, 5, c);
    skip(3000);
    is_horn = 1'b1;
    wait_grant(3'd5, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL horn_grant_latency: got %0d expected 1", c);
    end
    first_rise(1500, c);
    checks++;
    if (c != 1138) begin
      errors++; $display("FAIL horn_first_rise: got %0d expected 1138", c);
    end
    count_high(4547, h);
    checks++;
    if (h < 2260 || h > 2290) begin
      errors++; $display("FAIL horn_duty: got %0d highs expected 2260..2290", h);
    end
    is_horn = 1'b0;
    wait_grant(3'd3, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL horn_release_grant: got %0d expected 1", c);
    end
    first_rise(700, c);
    checks++;
    if (c != 627) begin
      errors++; $display("FAIL rev_resume_rise: got %0d expected 627", c);
    end
    count_high(5353, h);
    checks++;
    if (h == 0) begin
      errors++; $display("FAIL rev_resume_full_on: got %0d highs expected >0", h);
    end
    skip(24);
    count_high(5966, h);
    checks++;
    if (h != 0) begin
      errors++; $display("FAIL rev_resume_off: got %0d highs expected 0", h);
    end
    go_idle();
  endtask

  task automatic test_turn_click();
    int c, rise, dur, bad, seen2;
    turn_signal_on = 1'b1;
    wait_grant(3'd2, 5, c);
    checks++;
    if (c != 2) begin
      errors++; $display("FAIL turn_grant_latency: got %0d expected 2", c);
    end
    rise = -1; dur = -1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (grant != 3'd2) begin
        dur = n;
        break;
      end
      if (piezo_out && rise < 0) rise = n;
      if (n == 100) turn_signal_on = 1'b0;
      if (n == 150) turn_signal_on = 1'b1;
    end
    checks++;
    if (rise != 335) begin
      errors++; $display("FAIL turn_first_rise: got %0d expected 335", rise);
    end
    checks++;
    if (dur < 382 || dur > 401) begin
      errors++; $display("FAIL turn_duration: got %0d expected 382..401", dur);
    end
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (grant !== 3'd0 || piezo_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL turn_no_second_click: got %0d active cycles expected 0", bad);
    end
    go_idle();
    is_horn = 1'b1;
    wait_grant(3'd5, 5, c);
    skip(20);
    turn_signal_on = 1'b1;
    skip(50);
    is_horn = 1'b0;
    seen2 = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (grant == 3'd2) seen2++;
    end
    checks++;
    if (seen2 != 0) begin
      errors++; $display("FAIL turn_late_click: got %0d turn cycles expected 0", seen2);
    end
    checks++;
    if (grant !== 3'd0) begin
      errors++; $display("FAIL turn_drop_grant: got %0d expected 0", grant);
    end
    go_idle();
  endtask

  task automatic test_ess();
    int c, h, bad;
    engine_on = 1'b1; ess_active = 1'b1; is_reverse = 1'b1;
    wait_grant(3'd4, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL ess_grant_latency: got %0d expected 1", c);
    end
    first_rise(600, c);
    checks++;
    if (c != 502) begin
      errors++; $display("FAIL ess_first_rise: got %0d expected 502", c);
    end
    skip(498);
    engine_on = 1'b0;
    h = 0; bad = 0;
    for (int n = 0; n < 975; n++) begin
      @(negedge clk);
      if (piezo_out) h++;
      if (grant !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ess_engine_off_grant: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (h == 0) begin
      errors++; $display("FAIL ess_on_window: got %0d highs expected >0", h);
    end
    skip(29);
    count_high(1971, h);
    checks++;
    if (h != 0) begin
      errors++; $display("FAIL ess_off_window: got %0d highs expected 0", h);
    end
    first_rise(700, c);
    checks++;
    if (c < 508 || c > 527) begin
      errors++; $display("FAIL ess_restart_rise: got %0d expected 508..527", c);
    end
    go_idle();
  endtask

  task automatic test_engine_hum();
    int c, bad;
    engine_on = 1'b1; rpm = 14'd800;
`ifdef PIEZO_ENGINE_TONE_EN
    wait_grant(3'd1, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL eng_grant_latency: got %0d expected 1", c);
    end
    first_rise(3000, c);
    checks++;
    if (c != 2623) begin
      errors++; $display("FAIL eng_first_rise: got %0d expected 2623", c);
    end
`else
    bad = 0;
    c = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (grant !== 3'd0) bad++;
      if (piezo_out !== 1'b0) c++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL eng_disabled_grant: got %0d granted cycles expected 0", bad);
    end
    checks++;
    if (c != 0) begin
      errors++; $display("FAIL eng_disabled_piezo: got %0d high cycles expected 0", c);
    end
`endif
    go_idle();
  endtask

  task automatic test_reset_mid_beep();
    int c, h;
    ess_active = 1'b1;
    wait_grant(3'd4, 5, c);
    first_rise(600, c);
    skip(100);
    checks++;
    if (piezo_out !== 1'b1) begin
      errors++; $display("FAIL rst_pre_piezo: got %0b expected 1", piezo_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (piezo_out !== 1'b0) begin
      errors++; $display("FAIL rst_async_piezo: got %0b expected 0", piezo_out);
    end
    checks++;
    if (grant !== 3'd0) begin
      errors++; $display("FAIL rst_async_grant: got %0d expected 0", grant);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wait_grant(3'd4, 5, c);
    checks++;
    if (c != 1) begin
      errors++; $display("FAIL rst_regrant: got %0d expected 1", c);
    end
    first_rise(600, c);
    checks++;
    if (c != 502) begin
      errors++; $display("FAIL rst_restart_rise: got %0d expected 502", c);
    end
    count_high(1473, h);
    checks++;
    if (h != 973) begin
      errors++; $display("FAIL rst_full_on: got %0d highs expected 973", h);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_horn_preempt();
    test_turn_click();
    test_ess();
    test_engine_hum();
    test_reset_mid_beep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
